// File: rtl/kd_tree_pkg.sv
// Shared parameters and state type for the KD-tree traversal controller.
package kd_tree_pkg;

    localparam int unsigned DATA_WIDTH    = 55;
    localparam int unsigned STORAGE_WIDTH = 22;
    localparam int unsigned NUM_LEVELS    = 4;
    localparam int unsigned NUM_NODES     = 2 ** NUM_LEVELS - 1;
    localparam int unsigned PTR_W         = $clog2(NUM_NODES + 1);
    localparam int unsigned INFLIGHT_W    = $clog2(NUM_LEVELS + 2);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain
    } kd_ctrl_state_t;

endpackage

// File: rtl/kd_valid_pipe.sv
// Valid shift register mirroring the tree pipeline, plus an occupancy count.
module kd_valid_pipe #(
    parameter int unsigned Depth    = 4,
    parameter int unsigned CntWidth = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                out_valid_o,
    output logic [CntWidth-1:0] count_o
);

    logic [Depth-1:0]    sr_q, sr_d;
    logic [CntWidth-1:0] count_q, count_d;

    // Shift one slot per cycle; the count tracks entries minus exits.
    always_comb begin
        sr_d    = {sr_q[Depth-2:0], in_valid_i};
        count_d = count_q + CntWidth'(in_valid_i) - CntWidth'(sr_q[Depth-1]);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q    <= '0;
            count_q <= '0;
        end else begin
            sr_q    <= sr_d;
            count_q <= count_d;
        end
    end

    assign out_valid_o = sr_q[Depth-1];
    assign count_o     = count_q;

endmodule

// File: rtl/kd_tree_ctrl.sv
// KD-tree sequencer: configures nodes breadth-first, admits patches, drains before reload.
module kd_tree_ctrl
    import kd_tree_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_start_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [STORAGE_WIDTH-1:0] cfg_data_i,
    output logic [NUM_NODES-1:0]     node_wen_o,
    output logic [STORAGE_WIDTH-1:0] node_wdata_o,
    output logic                     load_done_o,
    input  logic                     patch_valid_i,
    output logic                     patch_ready_o,
    input  logic [DATA_WIDTH-1:0]    patch_in_i,
    output logic                     root_valid_o,
    output logic [DATA_WIDTH-1:0]    root_patch_o,
    output logic                     leaf_valid_o,
    output logic [INFLIGHT_W-1:0]    inflight_o,
    output logic                     busy_o
);

    kd_ctrl_state_t             state_q, state_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [NUM_NODES-1:0]       node_wen_q, node_wen_d;
    logic [STORAGE_WIDTH-1:0]   node_wdata_q, node_wdata_d;
    logic                       load_done_q, load_done_d;
    logic                       root_valid_q, root_valid_d;
    logic [DATA_WIDTH-1:0]      root_patch_q, root_patch_d;
    logic                       patch_hs;
    logic [NUM_NODES-1:0]       one_hot_base;

    assign one_hot_base = {{(NUM_NODES - 1){1'b0}}, 1'b1};

    // Readies depend on registered state only.
    assign cfg_ready_o   = (state_q == StLoad);
    assign patch_ready_o = (state_q == StRun);
    assign busy_o        = (state_q != StIdle);
    assign patch_hs      = patch_ready_o & patch_valid_i;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        node_wen_d   = '0;
        node_wdata_d = node_wdata_q;
        load_done_d  = load_done_q;
        root_valid_d = 1'b0;
        root_patch_d = root_patch_q;
        unique case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    state_d     = StLoad;
                    ptr_d       = '0;
                    load_done_d = 1'b0;
                end
            end
            StLoad: begin
                if (cfg_valid_i) begin
                    node_wen_d   = one_hot_base << ptr_q;
                    node_wdata_d = cfg_data_i;
                    ptr_d        = ptr_q + PTR_W'(1);
                    if (ptr_q == PTR_W'(NUM_NODES - 1)) begin
                        state_d     = StRun;
                        load_done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (patch_valid_i) begin
                    root_valid_d = 1'b1;
                    root_patch_d = patch_in_i;
                end
                // A patch arriving alongside load_start is still admitted.
                if (load_start_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (inflight_o == '0) begin
                    state_d     = StLoad;
                    ptr_d       = '0;
                    load_done_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            node_wen_q   <= '0;
            node_wdata_q <= '0;
            load_done_q  <= 1'b0;
            root_valid_q <= 1'b0;
            root_patch_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            node_wen_q   <= node_wen_d;
            node_wdata_q <= node_wdata_d;
            load_done_q  <= load_done_d;
            root_valid_q <= root_valid_d;
            root_patch_q <= root_patch_d;
        end
    end

    kd_valid_pipe #(
        .Depth    (NUM_LEVELS),
        .CntWidth (INFLIGHT_W)
    ) u_valid_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (patch_hs),
        .out_valid_o (leaf_valid_o),
        .count_o     (inflight_o)
    );

    assign node_wen_o   = node_wen_q;
    assign node_wdata_o = node_wdata_q;
    assign load_done_o  = load_done_q;
    assign root_valid_o = root_valid_q;
    assign root_patch_o = root_patch_q;

endmodule
